// File: rtl/mux4_rr_arbiter.sv
// Four-input round-robin arbiter driving a 4:1 mux select.
// A grant is held until the owner signals done, drops its request, or the
// hold limit expires. One empty RELEASE cycle always separates two grants.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8  // legal 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       sel1,
  output logic       sel2,
  output logic [3:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  // Last hold-counter value before rotation is forced
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [3:0] grant_q, grant_d;

  logic [1:0] winner;
  logic [1:0] scan_idx;
  logic       found;
  logic       any_req;
  logic       release_now;

  // Winner: first requester scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
  always_comb begin
    winner   = 2'd0;
    scan_idx = 2'd0;
    found    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

  // Owner is identified by the held select value
  assign release_now = done || !req[sel_q] || (hcnt_q == HoldLast);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    hcnt_d  = hcnt_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle, StRelease: begin
        if (any_req) begin
          state_d = StGrant;
          grant_d = 4'(4'b0001 << winner);
          sel_d   = winner;
          hcnt_d  = 8'd0;
        end else begin
          state_d = StIdle;
          grant_d = 4'b0000;
        end
      end
      StGrant: begin
        hcnt_d = (hcnt_q == 8'hFF) ? hcnt_q : hcnt_q + 8'd1;
        if (release_now) begin
          state_d = StRelease;
          grant_d = 4'b0000;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 4'b0000;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      hcnt_q  <= 8'd0;
      grant_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      hcnt_q  <= hcnt_d;
      grant_q <= grant_d;
    end
  end

  assign sel1  = sel_q[1];
  assign sel2  = sel_q[0];
  assign grant = grant_q;
  assign busy  = (state_q == StGrant);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: a vector table for the main flow plus
// hand-written sequences for simultaneous release causes and MAX_HOLD=1.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;

  logic       sel1, sel2, busy;
  logic [3:0] grant;
  logic       sel1_h1, sel2_h1, busy_h1;
  logic [3:0] grant_h1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  logic [3:0] pat_grant[4] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000};
  logic [1:0] pat_sel[4]   = '{2'b00, 2'b00, 2'b01, 2'b01};

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .sel1  (sel1),
    .sel2  (sel2),
    .grant (grant),
    .busy  (busy)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1)) dut_h1 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .sel1  (sel1_h1),
    .sel2  (sel2_h1),
    .grant (grant_h1),
    .busy  (busy_h1)
  );

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic d,
                     input logic [3:0] g, input logic [1:0] s, input logic b);
    vq.push_back('{r, q, d, g, s, b});
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later
  task automatic step(input logic r, input logic [3:0] q, input logic d);
    rst_n = r;
    req   = q;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    // Reset state
    add(0, 4'b0000, 0, 4'b0000, 2'b00, 0);
    add(0, 4'b0000, 0, 4'b0000, 2'b00, 0);
    // Single requester A held: 8 grant cycles then release
    add(1, 4'b0001, 0, 4'b0001, 2'b00, 1);
    for (int i = 0; i < 7; i++) add(1, 4'b0001, 0, 4'b0001, 2'b00, 1);
    add(1, 4'b0001, 0, 4'b0000, 2'b00, 0);
    add(1, 4'b0001, 0, 4'b0001, 2'b00, 1);
    // Request dropped mid-grant
    add(1, 4'b0000, 0, 4'b0000, 2'b00, 0);
    add(1, 4'b0000, 0, 4'b0000, 2'b00, 0);
    // Reset clears ptr (ptr was 1), then full rotation with done pulses
    add(0, 4'b1111, 0, 4'b0000, 2'b00, 0);
    add(1, 4'b1111, 1, 4'b0001, 2'b00, 1);  // done in IDLE ignored
    add(1, 4'b1111, 1, 4'b0000, 2'b00, 0);
    add(1, 4'b1111, 0, 4'b0010, 2'b01, 1);
    add(1, 4'b1111, 1, 4'b0000, 2'b01, 0);
    add(1, 4'b1111, 0, 4'b0100, 2'b10, 1);
    add(1, 4'b1111, 1, 4'b0000, 2'b10, 0);
    add(1, 4'b1111, 0, 4'b1000, 2'b11, 1);
    add(1, 4'b1111, 1, 4'b0000, 2'b11, 0);
    add(1, 4'b1111, 0, 4'b0001, 2'b00, 1);
    add(1, 4'b1111, 1, 4'b0000, 2'b00, 0);
    add(1, 4'b0000, 1, 4'b0000, 2'b00, 0);  // done in RELEASE ignored
    // ptr=1, only C requests: skip B with no extra latency
    add(1, 4'b0100, 0, 4'b0100, 2'b10, 1);
    add(1, 4'b0101, 0, 4'b0100, 2'b10, 1);
    add(1, 4'b0101, 1, 4'b0000, 2'b10, 0);  // ptr -> 3
    add(1, 4'b0101, 0, 4'b0001, 2'b00, 1);  // wraps to A
    add(1, 4'b0101, 1, 4'b0000, 2'b00, 0);
    add(1, 4'b0101, 0, 4'b0100, 2'b10, 1);  // then C
    // Owner B loses its request: release, idle, sel held at 01
    add(1, 4'b0000, 0, 4'b0000, 2'b10, 0);  // ptr -> 3
    add(1, 4'b0010, 0, 4'b0010, 2'b01, 1);
    add(1, 4'b0010, 0, 4'b0010, 2'b01, 1);
    add(1, 4'b0000, 0, 4'b0000, 2'b01, 0);
    add(1, 4'b0000, 0, 4'b0000, 2'b01, 0);
    add(1, 4'b0000, 1, 4'b0000, 2'b01, 0);
    // Reset during grant of D, no RELEASE, regrant right after reset
    add(1, 4'b1000, 0, 4'b1000, 2'b11, 1);
    add(0, 4'b1000, 0, 4'b0000, 2'b00, 0);
    add(1, 4'b1000, 0, 4'b1000, 2'b11, 1);
    add(1, 4'b0000, 0, 4'b0000, 2'b11, 0);
    add(1, 4'b0000, 0, 4'b0000, 2'b11, 0);

    foreach (vq[i]) begin
      step(vq[i].rst_n, vq[i].req, vq[i].done);
      check("grant", i, {4'b0, grant}, {4'b0, vq[i].grant});
      check("sel", i, {6'b0, sel1, sel2}, {6'b0, vq[i].sel});
      check("busy", i, {7'b0, busy}, {7'b0, vq[i].busy});
    end

    // done coincides with hold expiry: one release, ptr advances once
    step(0, 4'b0000, 0);
    step(1, 4'b0001, 0);
    check("hold_entry", 0, {4'b0, grant}, 8'h01);
    for (int i = 0; i < 7; i++) step(1, 4'b0001, 0);
    check("hold_last", 0, {4'b0, grant}, 8'h01);
    step(1, 4'b0011, 1);
    check("dual_release", 0, {4'b0, grant}, 8'h00);
    check("dual_busy", 0, {7'b0, busy}, 8'h00);
    step(1, 4'b0011, 0);
    check("dual_next_grant", 0, {4'b0, grant}, 8'h02);
    check("dual_next_sel", 0, {6'b0, sel1, sel2}, 8'h01);

    // MAX_HOLD=1 with A and B held: 0001,0000,0010,0000 repeating
    step(0, 4'b0000, 0);
    check("h1_reset", 0, {4'b0, grant_h1}, 8'h00);
    for (int i = 0; i < 12; i++) begin
      step(1, 4'b0011, 0);
      check("h1_grant", i, {4'b0, grant_h1}, {4'b0, pat_grant[i % 4]});
      check("h1_sel", i, {6'b0, sel1_h1, sel2_h1}, {6'b0, pat_sel[i % 4]});
      check("h1_busy", i, {7'b0, busy_h1}, {7'b0, (pat_grant[i % 4] != 4'b0000)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum cycles one grant is held before forced rotation (legal 1..255).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk.
REQ-004 Port: req  input  4  request per mux input; bit0=A, bit1=B, bit2=C, bit3=D.
REQ-005 Port: done  input  1  current owner finished; sampled only in GRANT.
REQ-006 Port: sel1  output  1  mux select MSB (registered).
REQ-007 Port: sel2  output  1  mux select LSB (registered); {sel1,sel2}=00/01/10/11 selects A/B/C/D.
REQ-008 Port: grant  output  4  one-hot grant, same bit order as req (registered).
REQ-009 Port: busy  output  1  high exactly when state is GRANT.

Function
REQ-010 Three states SHALL exist: IDLE, GRANT, RELEASE; plus a 2-bit priority pointer ptr and an 8-bit hold counter hcnt.
REQ-011 Winner selection SHALL be the first asserted req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 IDLE: if req!=0, next cycle state=GRANT, grant=onehot(winner), {sel1,sel2}=winner, hcnt=0; else stay IDLE.
REQ-013 Latency SHALL be one cycle: req sampled at edge N gives grant/sel valid after edge N.
REQ-014 GRANT: hcnt SHALL increment by 1 each cycle, saturating at 255.
REQ-015 GRANT exits to RELEASE when done=1, or req[owner]=0, or hcnt=MAX_HOLD-1; any one condition suffices.
REQ-016 On GRANT->RELEASE: grant=0000, ptr=(owner+1) mod 4, sel1/sel2 unchanged.
REQ-017 RELEASE lasts exactly one cycle (break-before-make); grant SHALL be 0000 throughout.
REQ-018 RELEASE: winner is computed with the updated ptr; if req!=0 go to GRANT (as REQ-012), else IDLE.
REQ-019 sel1/sel2 SHALL change only on entry to GRANT; they hold their last value in IDLE and RELEASE.
REQ-020 grant SHALL never have more than one bit set; grant bit index SHALL equal {sel1,sel2} whenever busy=1.
REQ-021 done asserted in IDLE or RELEASE SHALL be ignored.
REQ-022 With MAX_HOLD=1, a grant SHALL last exactly one cycle regardless of done/req.
REQ-023 Requests with ptr pointing at a non-requester SHALL skip it with no extra latency.
REQ-024 Simultaneous done=1 and hold expiry SHALL produce one RELEASE, one ptr advance.

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, grant=0000, sel1=0, sel2=0, busy=0, ptr=0, hcnt=0.
REQ-026 Reset asserted mid-GRANT SHALL drop grant/busy on that edge; no RELEASE cycle is produced.
REQ-027 After rst_n returns high, arbitration SHALL begin on the first edge with rst_n=1 and req!=0.
REQ-028 Before the first clock edge with rst_n=0, output values are unspecified; benches SHALL not check them.

Verification
REQ-029 Reset then req=0001, hold -> next cycle grant=0001, sel=00, busy=1; after 8 cycles (MAX_HOLD=8) RELEASE, grant=0000.
REQ-030 req=1111 constantly, done pulsed each grant cycle 1 -> grant order 0001,0010,0100,1000,0001, each separated by one 0000 cycle.
REQ-031 After owner C (ptr=3), req=0101 -> next grant=0001 (A), sel=00; then 0100 (C), sel=10.
REQ-032 Owner B granted, req changes to 0000 mid-grant -> RELEASE next cycle, then IDLE, sel held at 01, busy=0.
REQ-033 rst_n=0 during GRANT of D (sel=11) -> next edge grant=0000, sel=00, busy=0, ptr=0; req=1000 afterwards -> grant=1000 one cycle after rst_n=1.
REQ-034 MAX_HOLD=1, req=0011 held -> grant alternates 0001,0000,0010,0000 continuously.
